// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode sequencer driving the cpu datapath controls.
// Supported instructions: add, sub, and, or, addi, ld, sd. Any other encoding halts
// the unit in ILLEGAL until rst.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req/imem_addr              fetch request and address (address equals pc)
//   imem_ready/imem_data            fetch response
//   cpu_rf_addr_a/_b/_write_addr    rs1, rs2, rd
//   cpu_rf_write_en, cpu_dm_write_en  single-cycle write strobes
//   cpu_immediate                   sign-extended immediate
//   cpu_mux_0/1/2_sel, cpu_alu_operation  datapath selects and ALU op
//   pc, illegal                     program counter, halted flag
//   instret                         retired-instruction count (only with CU_INSTRET_COUNTER_EN)
module control_unit #(
    parameter int WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [WORDSIZE-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_data,
    output logic [4:0]          cpu_rf_addr_a,
    output logic [4:0]          cpu_rf_addr_b,
    output logic [4:0]          cpu_rf_write_addr,
    output logic                cpu_rf_write_en,
    output logic [WORDSIZE-1:0] cpu_immediate,
    output logic                cpu_mux_0_sel,
    output logic                cpu_mux_1_sel,
    output logic                cpu_mux_2_sel,
    output logic [2:0]          cpu_alu_operation,
    output logic                cpu_dm_write_en,
`ifdef CU_INSTRET_COUNTER_EN
    output logic [63:0]         instret,
`endif
    output logic [WORDSIZE-1:0] pc,
    output logic                illegal
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, ILLEGAL} state_t;
    state_t state, next;
    logic [31:0] ir;
    logic rf_we_q, dm_we_q, ld_q, sd_q;
    logic is_r, is_addi, is_ld, is_sd, ok, retire;
    logic [WORDSIZE-1:0] dec_imm;
    logic [2:0] dec_op;
    always_comb begin
        is_r = ir[6:0] == 7'b0110011 &&
               ((ir[31:25] == 7'b0000000 && (ir[14:12] == 3'b000 || ir[14:12] == 3'b111 || ir[14:12] == 3'b110)) ||
                (ir[31:25] == 7'b0100000 && ir[14:12] == 3'b000));
        is_addi = ir[6:0] == 7'b0010011 && ir[14:12] == 3'b000;
        is_ld = ir[6:0] == 7'b0000011 && ir[14:12] == 3'b011;
        is_sd = ir[6:0] == 7'b0100011 && ir[14:12] == 3'b011;
        ok = is_r || is_addi || is_ld || is_sd;
        dec_imm = is_sd ? {{(WORDSIZE-12){ir[31]}}, ir[31:25], ir[11:7]} :
                  is_r  ? '0 : {{(WORDSIZE-12){ir[31]}}, ir[31:20]};
        dec_op = !is_r ? 3'b000 : ir[30] ? 3'b001 :
                 ir[14:12] == 3'b111 ? 3'b010 : ir[14:12] == 3'b110 ? 3'b011 : 3'b000;
        retire = state == WB || (state == MEM && sd_q);
        next = state;
        case (state)
            FETCH:   next = (imem_req && imem_ready) ? DECODE : FETCH;
            DECODE:  next = ok ? EXECUTE : ILLEGAL;
            EXECUTE: next = (ld_q || sd_q) ? MEM : WB;
            MEM:     next = sd_q ? FETCH : WB;
            WB:      next = FETCH;
            default: next = ILLEGAL;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            ir <= '0;
            imem_req <= 1'b0;
            illegal <= 1'b0;
            rf_we_q <= 1'b0;
            dm_we_q <= 1'b0;
            ld_q <= 1'b0;
            sd_q <= 1'b0;
            cpu_rf_addr_a <= '0;
            cpu_rf_addr_b <= '0;
            cpu_rf_write_addr <= '0;
            cpu_immediate <= '0;
            cpu_mux_0_sel <= 1'b0;
            cpu_mux_1_sel <= 1'b0;
            cpu_mux_2_sel <= 1'b0;
            cpu_alu_operation <= '0;
`ifdef CU_INSTRET_COUNTER_EN
            instret <= '0;
`endif
        end else begin
            state <= next;
            imem_req <= next == FETCH;
            illegal <= next == ILLEGAL;
            rf_we_q <= next == WB;
            dm_we_q <= next == MEM && sd_q;
            if (state == FETCH && imem_req && imem_ready)
                ir <= imem_data;
            if (state == DECODE && ok) begin
                cpu_rf_addr_a <= ir[19:15];
                cpu_rf_addr_b <= ir[24:20];
                cpu_rf_write_addr <= ir[11:7];
                cpu_immediate <= dec_imm;
                cpu_mux_0_sel <= 1'b0;
                cpu_mux_1_sel <= is_r;
                cpu_mux_2_sel <= is_ld;
                cpu_alu_operation <= dec_op;
                ld_q <= is_ld;
                sd_q <= is_sd;
            end
            if (retire)
                pc <= pc + WORDSIZE'(4);
`ifdef CU_INSTRET_COUNTER_EN
            if (retire)
                instret <= instret + 64'd1;
`endif
        end
    end
    // Strobes are gated by rst so a reset landing mid-instruction kills the write in that cycle.
    assign cpu_rf_write_en = rf_we_q & ~rst;
    assign cpu_dm_write_en = dm_we_q & ~rst;
    assign imem_addr = pc;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic imem_req, imem_ready = 1'b0;
    logic [63:0] imem_addr, cpu_immediate, pc;
    logic [31:0] imem_data = 32'h0;
    logic [4:0] cpu_rf_addr_a, cpu_rf_addr_b, cpu_rf_write_addr;
    logic cpu_rf_write_en, cpu_mux_0_sel, cpu_mux_1_sel, cpu_mux_2_sel, cpu_dm_write_en, illegal;
    logic [2:0] cpu_alu_operation;
`ifdef CU_INSTRET_COUNTER_EN
    logic [63:0] instret;
`endif
    int n_chk = 0;
    int n_bad = 0;
    int we_cyc, we_n, dm_cyc, dm_n;

    control_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
        .cpu_rf_addr_a(cpu_rf_addr_a), .cpu_rf_addr_b(cpu_rf_addr_b),
        .cpu_rf_write_addr(cpu_rf_write_addr), .cpu_rf_write_en(cpu_rf_write_en),
        .cpu_immediate(cpu_immediate), .cpu_mux_0_sel(cpu_mux_0_sel),
        .cpu_mux_1_sel(cpu_mux_1_sel), .cpu_mux_2_sel(cpu_mux_2_sel),
        .cpu_alu_operation(cpu_alu_operation), .cpu_dm_write_en(cpu_dm_write_en),
`ifdef CU_INSTRET_COUNTER_EN
        .instret(instret),
`endif
        .pc(pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at the negedge of the first FETCH cycle (imem_req=1). Returns at the
    // negedge where pc has advanced, or after a bound of 20 cycles.
    task automatic exec(input logic [31:0] ins, input int d,
                        output int wc, output int wn, output int dc, output int dn);
        logic [63:0] pc0;
        pc0 = pc;
        wc = 0; wn = 0; dc = 0; dn = 0;
        imem_data = ins;
        for (int c = 1; c <= 20; c++) begin
            if (pc !== pc0) break;
            if (cpu_rf_write_en) begin wc = c; wn++; end
            if (cpu_dm_write_en) begin dc = c; dn++; end
            imem_ready = (c == d + 1);
            @(negedge clk);
        end
        imem_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 64'h0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addrs", {cpu_rf_addr_a, cpu_rf_addr_b, cpu_rf_write_addr}, 15'h0);
        chk("rst_imm", cpu_immediate, 64'h0);
        chk("rst_sel_op", {cpu_mux_0_sel, cpu_mux_1_sel, cpu_mux_2_sel, cpu_alu_operation}, 6'h0);
        chk("rst_strobes", {cpu_rf_write_en, cpu_dm_write_en}, 2'b00);
        // ready while imem_req is still low must be ignored (data would be illegal)
        rst = 1'b0; imem_ready = 1'b1; imem_data = 32'h0;
        @(negedge clk);
        chk("req_after_rst", imem_req, 1'b1);
        chk("ready_ignored", illegal, 1'b0);
        imem_ready = 1'b0;

        exec(32'h00500093, 0, we_cyc, we_n, dm_cyc, dm_n);
        chk("addi_we_cyc", we_cyc, 4);
        chk("addi_we_n", we_n, 1);
        chk("addi_dm_n", dm_n, 0);
        chk("addi_pc", pc, 64'd4);
        chk("addi_imem_addr", imem_addr, 64'd4);
        chk("addi_a_wa", {cpu_rf_addr_a, cpu_rf_write_addr}, {5'd0, 5'd1});
        chk("addi_imm", cpu_immediate, 64'd5);
        chk("addi_sel_op", {cpu_mux_0_sel, cpu_mux_1_sel, cpu_mux_2_sel, cpu_alu_operation}, 6'b000_000);

        exec(32'h402081B3, 0, we_cyc, we_n, dm_cyc, dm_n);
        chk("sub_addrs", {cpu_rf_addr_a, cpu_rf_addr_b, cpu_rf_write_addr}, {5'd1, 5'd2, 5'd3});
        chk("sub_sel_op", {cpu_mux_0_sel, cpu_mux_1_sel, cpu_mux_2_sel, cpu_alu_operation}, 6'b010_001);
        chk("sub_we", {we_n, we_cyc}, {32'd1, 32'd4});
        chk("sub_pc", pc, 64'd8);

        exec(32'h0020F233, 0, we_cyc, we_n, dm_cyc, dm_n);
        chk("and_op", cpu_alu_operation, 3'b010);
        chk("and_wa", cpu_rf_write_addr, 5'd4);
        exec(32'h0020E2B3, 0, we_cyc, we_n, dm_cyc, dm_n);
        chk("or_op", cpu_alu_operation, 3'b011);
        chk("or_pc", pc, 64'd16);

        exec(32'hFE813C23, 0, we_cyc, we_n, dm_cyc, dm_n);
        chk("sd_imm", cpu_immediate, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("sd_dm", {dm_n, dm_cyc}, {32'd1, 32'd4});
        chk("sd_we_n", we_n, 0);
        chk("sd_pc", pc, 64'd20);

        exec(32'h01013283, 3, we_cyc, we_n, dm_cyc, dm_n);
        chk("ld_mux2", cpu_mux_2_sel, 1'b1);
        chk("ld_imm", cpu_immediate, 64'd16);
        chk("ld_we", {we_n, we_cyc}, {32'd1, 32'd8});
        chk("ld_dm_n", dm_n, 0);
        chk("ld_pc", pc, 64'd24);

        exec(32'h00000063, 0, we_cyc, we_n, dm_cyc, dm_n);
        chk("beq_illegal", illegal, 1'b1);
        chk("beq_req", imem_req, 1'b0);
        chk("beq_pc", pc, 64'd24);
        chk("beq_strobes", we_n + dm_n, 0);
        chk("beq_ctl_held", cpu_rf_write_addr, 5'd5);

        rst = 1'b1;
        @(negedge clk);
        chk("rst2_pc", pc, 64'h0);
        chk("rst2_illegal", illegal, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // sd with rst raised during its MEM cycle
        imem_data = 32'hFE813C23; imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("sd_mem_dm_pre", cpu_dm_write_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("sd_mem_dm_rst", cpu_dm_write_en, 1'b0);
        @(negedge clk);
        chk("sd_rst_pc", pc, 64'h0);
        chk("sd_rst_req", imem_req, 1'b0);
        chk("sd_rst_dm", cpu_dm_write_en, 1'b0);
`ifdef CU_INSTRET_COUNTER_EN
        chk("instret_rst", instret, 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("sd_rst_fetch", imem_req, 1'b1);
        exec(32'h00500093, 0, we_cyc, we_n, dm_cyc, dm_n);
        exec(32'h402081B3, 0, we_cyc, we_n, dm_cyc, dm_n);
        exec(32'hFE813C23, 0, we_cyc, we_n, dm_cyc, dm_n);
        chk("three_pc", pc, 64'd12);
`ifdef CU_INSTRET_COUNTER_EN
        chk("instret_3", instret, 64'd3);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
